bcd2bin_converter: RTL

BCD2BIN_CONVERTER -- requirements
Module: bcd2bin_converter

---
 rtl/bcd2bin_converter_if.sv | 24 ++
 rtl/bcd2bin_converter.sv | 118 +++++++++++
 2 files changed

// File: rtl/bcd2bin_converter_if.sv
// Handshake and result bundle for the BCD to binary converter.
// The master side issues start/bcd_in and observes the result flags;
// the slave side is the converter itself.
interface bcd2bin_converter_if #(
  parameter int BIN_W = 12
);
  logic             start;
  logic [15:0]      bcd_in;
  logic [BIN_W-1:0] bin_out;
  logic             busy;
  logic             done;
  logic             ovf;
  logic             err;

  modport master (
    output start, bcd_in,
    input  bin_out, busy, done, ovf, err
  );

  modport slave (
    input  start, bcd_in,
    output bin_out, busy, done, ovf, err
  );
endinterface

// File: rtl/bcd2bin_converter.sv
// Sequential 4-digit BCD to binary converter (reverse double-dabble).
// A 30-bit working register {16 BCD bits, 14 binary bits} is shifted right
// 14 times; after each shift every BCD nibble >= 8 is corrected by -3.
// Optional macro BCD2BIN_SAT_EN: results that do not fit in BIN_W bits
// saturate to all ones instead of wrapping. ovf/err behave the same either way.
module bcd2bin_converter #(
  parameter int BIN_W = 12
) (
  input  logic               clk,
  input  logic               rst,
  bcd2bin_converter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CONV = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] LAST_ITER = 4'd13;

  logic [1:0]       state;
  logic [3:0]       iter_cnt;
  logic [29:0]      work;
  logic [29:0]      shifted;
  logic [29:0]      next_work;
  logic [13:0]      result;
  logic             res_ovf;
  logic [BIN_W-1:0] res_bin;
  logic             in_err;
  logic [BIN_W-1:0] bin_q;
  logic             ovf_q;
  logic             err_q;
  logic             done_q;

  // One reverse double-dabble step plus the result formatting for the final step
  always_comb begin
    shifted   = work >> 1;
    next_work = shifted;
    for (int i = 0; i < 4; i++) begin
      if (shifted[14 + 4*i + 3]) begin
        next_work[14 + 4*i +: 4] = shifted[14 + 4*i +: 4] - 4'd3;
      end
    end
    result  = next_work[13:0];
    res_ovf = ({1'b0, result} >= (15'd1 << BIN_W));
`ifdef BCD2BIN_SAT_EN
    res_bin = res_ovf ? '1 : result[BIN_W-1:0];
`else
    res_bin = result[BIN_W-1:0];
`endif
  end

  // Flag any input nibble that is not a decimal digit (10..15)
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.bcd_in[4*i + 3] && (bus.bcd_in[4*i + 2] || bus.bcd_in[4*i + 1])) begin
        in_err = 1'b1;
      end
    end
  end

  // Control FSM, working register and registered result outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      iter_cnt <= 4'd0;
      work     <= 30'd0;
      bin_q    <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            work     <= {bus.bcd_in, 14'd0};
            iter_cnt <= 4'd0;
            if (in_err) begin
              state  <= DONE;
              bin_q  <= '0;
              ovf_q  <= 1'b0;
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end else begin
              state <= CONV;
            end
          end
        end
        CONV: begin
          work <= next_work;
          if (iter_cnt == LAST_ITER) begin
            state  <= DONE;
            bin_q  <= res_bin;
            ovf_q  <= res_ovf;
            err_q  <= 1'b0;
            done_q <= 1'b1;
          end else begin
            iter_cnt <= iter_cnt + 4'd1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.bin_out = bin_q;
  assign bus.ovf     = ovf_q;
  assign bus.err     = err_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state != IDLE);

endmodule
